// File: rtl/bless_router_age.sv
// bless_router_age: BLESS deflection router with oldest-first allocation and local injection FIFO (optional stats: BLESS_STATS_EN)
module bless_router_age #(
  parameter int DATA_WIDTH = 64,
  parameter int X_W        = 3,
  parameter int Y_W        = 3,
  parameter int AGE_W      = 4,
  parameter int CORD_X     = 0,
  parameter int CORD_Y     = 0,
  parameter int INJ_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [DATA_WIDTH-1:0]         data_in_0,
  input  logic [DATA_WIDTH-1:0]         data_in_1,
  input  logic [DATA_WIDTH-1:0]         data_in_2,
  input  logic [DATA_WIDTH-1:0]         data_in_3,
  output logic [DATA_WIDTH-1:0]         data_out_0,
  output logic [DATA_WIDTH-1:0]         data_out_1,
  output logic [DATA_WIDTH-1:0]         data_out_2,
  output logic [DATA_WIDTH-1:0]         data_out_3,
  output logic [DATA_WIDTH-1:0]         data_out_4,
  input  logic [DATA_WIDTH-1:0]         inj_data,
  input  logic                          inj_valid,
  output logic                          inj_ready,
  output logic [$clog2(INJ_DEPTH):0]    inj_count
`ifdef BLESS_STATS_EN
  ,
  output logic [31:0]                   defl_count,
  output logic [31:0]                   inj_stall_count
`endif
);
  localparam int VB = DATA_WIDTH - 1;
  localparam int XH = DATA_WIDTH - 2;
  localparam int YH = XH - X_W;
  localparam int AH = YH - Y_W;
  localparam int PW = AH - AGE_W + 1;
  localparam int AW = $clog2(INJ_DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [2:0] route(input logic [DATA_WIDTH-1:0] f);
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    x = f[XH -: X_W];
    y = f[YH -: Y_W];
    return x > X_W'(CORD_X) ? 3'd1 :
           x < X_W'(CORD_X) ? 3'd3 :
           y > Y_W'(CORD_Y) ? 3'd0 :
           y < Y_W'(CORD_Y) ? 3'd2 : 3'd4;
  endfunction

  function automatic logic [AGE_W-1:0] age_of(input logic [DATA_WIDTH-1:0] f);
    return f[AH -: AGE_W];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] bump(input logic [DATA_WIDTH-1:0] f);
    logic [AGE_W-1:0] a;
    a = f[AH -: AGE_W];
    return {f[VB:AH+1], (&a) ? a : a + AGE_W'(1), f[PW-1:0]};
  endfunction

  logic [DATA_WIDTH-1:0] din [4];
  logic [DATA_WIDTH-1:0] s1 [4];
  logic [DATA_WIDTH-1:0] mem [INJ_DEPTH];
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] nxt [5];
  logic [DATA_WIDTH-1:0] f;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [2:0]            rt [4];
  logic [1:0]            rank [4];
  logic [2:0]            nv, r, port;
  logic                  eg, push, pop, fv, ejected;
  logic [3:0]            claimed;
`ifdef BLESS_STATS_EN
  logic [2:0]            ndefl;
`endif

  assign din       = '{data_in_0, data_in_1, data_in_2, data_in_3};
  assign inj_ready = inj_count < CW'(INJ_DEPTH);
  assign push      = inj_valid && inj_ready;
  assign pop       = (inj_count != '0) && (nv - 3'(eg) < 3'd4);
  assign head      = {1'b1, mem[rd_ptr][VB-1:AH+1], {AGE_W{1'b0}}, mem[rd_ptr][PW-1:0]};

  // stage 1: capture neighbour flits every cycle, invalid flits clear the slot
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) for (int i = 0; i < 4; i++) s1[i] <= '0;
    else for (int i = 0; i < 4; i++) s1[i] <= din[i][VB] ? din[i] : '0;

  // injection FIFO storage; occupancy gates every read so no reset is needed
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= inj_data;

  // injection FIFO pointers and occupancy
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      inj_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      inj_count <= inj_count + CW'(push) - CW'(pop);
    end

  // routes, occupancy, pending ejection and oldest-first rank of each stage-1 slot
  always_comb begin
    nv = '0;
    eg = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rt[i] = route(s1[i]);
      nv = nv + 3'(s1[i][VB]);
      eg = eg | (s1[i][VB] && rt[i] == 3'd4);
      rank[i] = '0;
      for (int j = 0; j < 4; j++)
        if (j != i && s1[j][VB] && (age_of(s1[j]) > age_of(s1[i]) ||
            (age_of(s1[j]) == age_of(s1[i]) && j < i)))
          rank[i] = rank[i] + 2'd1;
    end
  end

  // allocate in rank order, injected head last; losers deflect to lowest free network port
  always_comb begin
    for (int p = 0; p < 5; p++) nxt[p] = '0;
    claimed = '0;
    ejected = 1'b0;
    fv = 1'b0;
    f = '0;
    r = 3'd4;
    port = 3'd4;
`ifdef BLESS_STATS_EN
    ndefl = '0;
`endif
    for (int p = 0; p < 5; p++) begin
      fv = 1'b0;
      f = '0;
      r = 3'd4;
      if (p == 4) begin
        fv = pop;
        f = head;
        r = route(head);
      end else begin
        for (int i = 0; i < 4; i++)
          if (s1[i][VB] && rank[i] == 2'(p)) begin
            fv = 1'b1;
            f = s1[i];
            r = rt[i];
          end
      end
      if (fv) begin
        if (r == 3'd4 && !ejected) begin
          nxt[4] = f;
          ejected = 1'b1;
        end else begin
          port = r;
          if (r == 3'd4 || claimed[r[1:0]]) begin
            for (int k = 3; k >= 0; k--) if (!claimed[k]) port = 3'(k);
`ifdef BLESS_STATS_EN
            ndefl = ndefl + 3'd1;
`endif
          end
          claimed[port[1:0]] = 1'b1;
          nxt[port] = bump(f);
        end
      end
    end
  end

  // stage 2: register allocation results onto the output ports
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      data_out_0 <= '0;
      data_out_1 <= '0;
      data_out_2 <= '0;
      data_out_3 <= '0;
      data_out_4 <= '0;
    end else begin
      data_out_0 <= nxt[0];
      data_out_1 <= nxt[1];
      data_out_2 <= nxt[2];
      data_out_3 <= nxt[3];
      data_out_4 <= nxt[4];
    end

`ifdef BLESS_STATS_EN
  // deflection and injection-stall statistics
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      defl_count      <= '0;
      inj_stall_count <= '0;
    end else begin
      defl_count <= defl_count + 32'(ndefl);
      if (inj_count != '0 && !pop) inj_stall_count <= inj_stall_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_bless_router_age.sv
// tb_bless_router_age: directed scoreboard bench for bless_router_age at node (1,1)
module tb_bless_router_age;
  localparam logic [63:0] Z = 64'h0;

  typedef struct {
    int               due;
    logic [4:0][63:0] o;
  } exp_t;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [63:0]       d0, d1, d2, d3, inj_data;
  logic [63:0]       data_out_0, data_out_1, data_out_2, data_out_3, data_out_4;
  logic              inj_valid, inj_ready;
  logic [2:0]        inj_count;
  logic [4:0][63:0]  obs;
`ifdef BLESS_STATS_EN
  logic [31:0]       defl_count, inj_stall_count;
`endif
  int   vec = 0;
  int   miss = 0;
  int   ec = 0;
  exp_t q[$];
  logic [52:0] rp [4];
  logic [63:0] ld [4];

  bless_router_age #(.CORD_X(1), .CORD_Y(1)) dut (
    .clk(clk), .n_rst(n_rst),
    .data_in_0(d0), .data_in_1(d1), .data_in_2(d2), .data_in_3(d3),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .data_out_3(data_out_3), .data_out_4(data_out_4),
    .inj_data(inj_data), .inj_valid(inj_valid), .inj_ready(inj_ready),
    .inj_count(inj_count)
`ifdef BLESS_STATS_EN
    , .defl_count(defl_count), .inj_stall_count(inj_stall_count)
`endif
  );

  assign obs = {data_out_4, data_out_3, data_out_2, data_out_1, data_out_0};

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [2:0] x, input logic [2:0] y,
                                     input logic [3:0] a, input logic [52:0] p);
    return {1'b1, x, y, a, p};
  endfunction

  function automatic logic [63:0] inj(input logic [2:0] x, input logic [2:0] y,
                                      input logic [3:0] a, input logic [52:0] p);
    return {1'b0, x, y, a, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    vec++;
    assert (o === e) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic step(input logic [63:0] i0, input logic [63:0] i1, input logic [63:0] i2,
                      input logic [63:0] i3, input logic pv, input logic [63:0] pd,
                      input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2,
                      input logic [63:0] e3, input logic [63:0] e4);
    exp_t e;
    d0 = i0; d1 = i1; d2 = i2; d3 = i3;
    inj_valid = pv;
    inj_data = pd;
    q.push_back('{due: ec + 2, o: {e4, e3, e2, e1, e0}});
    @(posedge clk);
    ec++;
    #1;
    while (q.size() > 0 && q[0].due == ec) begin
      e = q.pop_front();
      for (int p = 0; p < 5; p++) chk($sformatf("out%0d@edge%0d", p, ec), obs[p], e.o[p]);
    end
  endtask

  task automatic idle();
    step(Z, Z, Z, Z, 1'b0, Z, Z, Z, Z, Z, Z);
  endtask

  initial begin
    n_rst = 1'b0;
    d0 = Z; d1 = Z; d2 = Z; d3 = Z;
    inj_valid = 1'b0;
    inj_data = Z;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out0", data_out_0, Z);
    chk("rst_out1", data_out_1, Z);
    chk("rst_out2", data_out_2, Z);
    chk("rst_out3", data_out_3, Z);
    chk("rst_out4", data_out_4, Z);
    chk("rst_count", 64'(inj_count), 64'd0);
    chk("rst_ready", 64'(inj_ready), 64'd1);
    n_rst = 1'b1;
    // single flit west->east, age 0->1
    step(Z, Z, Z, mk(2, 1, 0, 53'h1_2345_6789_abcd), 1'b0, Z,
         Z, mk(2, 1, 1, 53'h1_2345_6789_abcd), Z, Z, Z);
    // oldest wins east, younger deflects to N
    step(mk(2, 1, 5, 53'h22), Z, mk(2, 1, 3, 53'h33), Z, 1'b0, Z,
         mk(2, 1, 4, 53'h33), mk(2, 1, 6, 53'h22), Z, Z, Z);
    // equal ages: lower index wins W
    step(Z, mk(0, 1, 2, 53'h44), Z, mk(0, 1, 2, 53'h55), 1'b0, Z,
         mk(0, 1, 3, 53'h55), Z, Z, mk(0, 1, 3, 53'h44), Z);
    // two ejecting flits: older ejects, other deflects
    step(mk(1, 1, 2, 53'h66), mk(1, 1, 7, 53'h77), Z, Z, 1'b0, Z,
         mk(1, 1, 3, 53'h66), Z, Z, Z, mk(1, 1, 7, 53'h77));
    // four flits all east, ordered by age
    step(mk(2, 1, 1, 53'h81), mk(2, 1, 2, 53'h82), mk(2, 1, 3, 53'h83), mk(2, 1, 4, 53'h84), 1'b0, Z,
         mk(2, 1, 4, 53'h83), mk(2, 1, 5, 53'h84), mk(2, 1, 3, 53'h82), mk(2, 1, 2, 53'h81), Z);
    // north and south routes
    step(mk(1, 2, 0, 53'h91), mk(1, 0, 0, 53'h92), Z, Z, 1'b0, Z,
         mk(1, 2, 1, 53'h91), Z, mk(1, 0, 1, 53'h92), Z, Z);
    // age saturation
    step(Z, Z, mk(0, 1, 15, 53'ha1), Z, 1'b0, Z,
         Z, Z, Z, mk(0, 1, 15, 53'ha1), Z);
    // local injection ejects with age cleared and valid forced
    step(Z, Z, Z, Z, 1'b1, inj(1, 1, 5, 53'hb1),
         Z, Z, Z, Z, mk(1, 1, 0, 53'hb1));
    idle();
    // local injection loses ejection to a network flit and deflects
    step(mk(1, 1, 3, 53'hc1), Z, Z, Z, 1'b1, inj(1, 1, 0, 53'hc2),
         mk(1, 1, 1, 53'hc2), Z, Z, Z, mk(1, 1, 3, 53'hc1));
    idle();
    idle();
    chk("drained_count", 64'(inj_count), 64'd0);
    // back-pressure: full network load blocks injection
    for (int k = 0; k < 4; k++) begin
      rp[k] = 53'hd00 + 53'(k);
      ld[k] = mk(2, 1, 0, 53'he00 + 53'(k));
    end
    for (int k = 0; k < 4; k++) begin
      step(ld[0], ld[1], ld[2], ld[3], 1'b1, inj(0, 1, 9, rp[k]),
           mk(2, 1, 1, 53'he01), mk(2, 1, 1, 53'he00), mk(2, 1, 1, 53'he02), mk(2, 1, 1, 53'he03), Z);
      chk($sformatf("fill_count%0d", k), 64'(inj_count), 64'(k + 1));
      chk($sformatf("fill_ready%0d", k), 64'(inj_ready), (k < 3) ? 64'd1 : 64'd0);
    end
    step(ld[0], ld[1], ld[2], ld[3], 1'b0, Z,
         mk(2, 1, 1, 53'he01), mk(2, 1, 1, 53'he00), mk(2, 1, 1, 53'he02), mk(2, 1, 1, 53'he03), Z);
    chk("hold_count", 64'(inj_count), 64'd4);
    // drop load to three: one injection per cycle on W
    for (int k = 0; k < 5; k++) begin
      step(ld[0], ld[1], ld[2], Z, 1'b0, Z,
           mk(2, 1, 1, 53'he01), mk(2, 1, 1, 53'he00), mk(2, 1, 1, 53'he02),
           (k < 4) ? mk(0, 1, 1, rp[k]) : Z, Z);
      chk($sformatf("drain_count%0d", k), 64'(inj_count), (k == 0) ? 64'd4 : 64'(4 - k));
      if (k == 1) chk("drain_ready", 64'(inj_ready), 64'd1);
    end
    idle();
    idle();
    // asynchronous reset in the middle of traffic
    d0 = ld[0]; d1 = ld[1]; d2 = ld[2]; d3 = ld[3];
    inj_valid = 1'b1;
    inj_data = inj(0, 1, 0, 53'hf1);
    repeat (2) @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_out0", data_out_0, Z);
    chk("mid_rst_out1", data_out_1, Z);
    chk("mid_rst_out2", data_out_2, Z);
    chk("mid_rst_out3", data_out_3, Z);
    chk("mid_rst_out4", data_out_4, Z);
    chk("mid_rst_count", 64'(inj_count), 64'd0);
    chk("mid_rst_ready", 64'(inj_ready), 64'd1);
`ifdef BLESS_STATS_EN
    chk("mid_rst_defl", 64'(defl_count), 64'd0);
    chk("mid_rst_stall", 64'(inj_stall_count), 64'd0);
`endif
    d0 = Z; d1 = Z; d2 = Z; d3 = Z;
    inj_valid = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    // recovery after reset
    step(Z, mk(1, 2, 8, 53'hf2), Z, Z, 1'b0, Z,
         mk(1, 2, 9, 53'hf2), Z, Z, Z, Z);
    idle();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
